// File: rtl/judge3_vote_panel.sv
// Judge panel front end: opens a timed voting window on start, latches each
// judge's button press, and presents the majority verdict over valid/ready.
module judge3_vote_panel #(
  parameter int unsigned WIN_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  output logic       busy,
  output logic [2:0] votes,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       pass
);

  localparam int unsigned CW = $clog2(WIN_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VOTE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_nx;
  logic [2:0]     votes_q, votes_nx;
  logic           pass_q, pass_nx;
  logic [CW-1:0]  cnt_q, cnt_nx;
  logic [2:0]     votes_or;
  logic           last_cycle;

  // Sticky vote accumulation including any press on the current cycle.
  assign votes_or   = votes_q | {btn_a, btn_b, btn_c};
  assign last_cycle = (cnt_q == CW'(WIN_CYCLES - 1));

  // State, vote, verdict and window-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      votes_q <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_nx;
      votes_q <= votes_nx;
      pass_q  <= pass_nx;
      cnt_q   <= cnt_nx;
    end
  end

  // Next-state logic; verdict is computed from the updated votes on exit
  // so that a press on the exit cycle still counts.
  always_comb begin
    state_nx = state_q;
    votes_nx = votes_q;
    pass_nx  = pass_q;
    cnt_nx   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_nx = VOTE;
          votes_nx = '0;
          pass_nx  = 1'b0;
          cnt_nx   = '0;
        end
      end
      VOTE: begin
        votes_nx = votes_or;
        cnt_nx   = cnt_q + CW'(1);
        if ((votes_or == 3'b111) || last_cycle) begin
          state_nx = DONE;
          pass_nx  = (votes_or[2] & votes_or[1]) |
                     (votes_or[2] & votes_or[0]) |
                     (votes_or[1] & votes_or[0]);
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy      = (state_q != IDLE);
    res_valid = (state_q == DONE);
    votes     = votes_q;
    pass      = pass_q;
  end

endmodule

// File: tb/tb_judge3_vote_panel.sv
// Self-checking bench for judge3_vote_panel with an 8-cycle voting window.
module tb_judge3_vote_panel;

  localparam int unsigned WIN = 8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       btn_a;
  logic       btn_b;
  logic       btn_c;
  logic       busy;
  logic [2:0] votes;
  logic       res_valid;
  logic       res_ready;
  logic       pass;

  int unsigned vecs;
  int unsigned errs;

  // Expected {votes, pass} per window, pushed when stimulus is driven.
  logic [3:0] sb[$];

  judge3_vote_panel #(.WIN_CYCLES(WIN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .btn_a     (btn_a),
    .btn_b     (btn_b),
    .btn_c     (btn_c),
    .busy      (busy),
    .votes     (votes),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .pass      (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    int n;
    n = int'(v[2]) + int'(v[1]) + int'(v[0]);
    return (n >= 2);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [2:0] b);
    {btn_a, btn_b, btn_c} = b;
  endtask

  // Drives one window (optionally opening it with start); pat holds the
  // button pattern for VOTE cycle k in bits [3k+:3]. Pushes the expected
  // verdict and reports expected vs observed number of VOTE cycles.
  task automatic run_window(input bit do_start, input logic [23:0] pat,
                            output int exp_len, output int obs_len);
    logic [2:0] acc;
    if (do_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    acc = '0;
    exp_len = 0;
    for (int i = 0; i < int'(WIN); i++) begin
      if (exp_len == 0) begin
        acc = acc | pat[3*i +: 3];
        if (acc == 3'b111 || i == int'(WIN) - 1) exp_len = i + 1;
      end
    end
    sb.push_back({acc, maj(acc)});
    obs_len = 0;
    for (int i = 0; i < 2 * int'(WIN); i++) begin
      if (i < int'(WIN)) set_btn(pat[3*i +: 3]);
      else set_btn(3'b000);
      tick();
      if (res_valid === 1'b1) begin
        obs_len = i + 1;
        break;
      end
    end
    set_btn(3'b000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; res_ready = 1'b0; set_btn(3'b000);
    #12;
    vecs++;
    if ({busy, votes, res_valid, pass} !== 6'b0) begin
      errs++;
      $display("FAIL reset_state: got busy=%b votes=%b valid=%b pass=%b, want all 0",
               busy, votes, res_valid, pass);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; tick(); start = 1'b0;
    set_btn(3'b101); tick(); set_btn(3'b000);
    vecs++;
    if (votes !== 3'b101 || busy !== 1'b1) begin
      errs++;
      $display("FAIL mid_pre_reset: got votes=%b busy=%b, want 101 1", votes, busy);
    end
    #3;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({busy, votes, res_valid, pass} !== 6'b0) begin
      errs++;
      $display("FAIL mid_async_reset: got busy=%b votes=%b valid=%b pass=%b, want all 0",
               busy, votes, res_valid, pass);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Checks the verdict presented in DONE against the scoreboard head.
  task automatic test_verdict(input string name, input int exp_len, input int obs_len);
    logic [3:0] e;
    vecs++;
    if (obs_len !== exp_len) begin
      errs++;
      $display("FAIL %s_len: got %0d vote cycles, want %0d", name, obs_len, exp_len);
    end
    e = (sb.size() > 0) ? sb.pop_front() : 4'hx;
    vecs++;
    if ({votes, pass} !== e || busy !== 1'b1) begin
      errs++;
      $display("FAIL %s_verdict: got votes=%b pass=%b busy=%b, want votes=%b pass=%b busy=1",
               name, votes, pass, busy, e[3:1], e[0]);
    end
  endtask

  task automatic handshake();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_early_unanimous();
    int el, ol;
    run_window(1'b1, 24'h0 | (24'b100 << 3) | (24'b010 << 6) | (24'b001 << 9), el, ol);
    test_verdict("early_unanimous", el, ol);
    handshake();
  endtask

  task automatic test_timeout_majority();
    int el, ol;
    run_window(1'b1, (24'b010 << 3) | (24'b001 << 21), el, ol);
    test_verdict("timeout_majority", el, ol);
    handshake();
  endtask

  task automatic test_minority_and_empty();
    int el, ol;
    run_window(1'b1, (24'b100 << 6), el, ol);
    test_verdict("minority", el, ol);
    handshake();
    run_window(1'b1, 24'h0, el, ol);
    test_verdict("no_votes", el, ol);
    handshake();
  endtask

  task automatic test_stall();
    int el, ol;
    logic [2:0] held_v;
    logic       held_p;
    run_window(1'b1, 24'b101, el, ol);
    test_verdict("stall_window", el, ol);
    held_v = 3'b101;
    held_p = 1'b1;
    for (int i = 0; i < 5; i++) begin
      res_ready = 1'b0;
      set_btn(3'($urandom_range(7)));
      start = 1'($urandom_range(1));
      tick();
      vecs++;
      if (res_valid !== 1'b1 || votes !== held_v || pass !== held_p) begin
        errs++;
        $display("FAIL stall_hold: got valid=%b votes=%b pass=%b, want 1 %b %b",
                 res_valid, votes, pass, held_v, held_p);
      end
    end
    set_btn(3'b000); start = 1'b0;
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    vecs++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || votes !== held_v || pass !== held_p) begin
      errs++;
      $display("FAIL stall_release: got busy=%b valid=%b votes=%b pass=%b, want 0 0 %b %b",
               busy, res_valid, votes, pass, held_v, held_p);
    end
    start = 1'b1; tick(); start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || votes !== 3'b000 || pass !== 1'b0) begin
      errs++;
      $display("FAIL stall_restart: got busy=%b votes=%b pass=%b, want 1 000 0",
               busy, votes, pass);
    end
    run_window(1'b0, 24'h0, el, ol);
    test_verdict("stall_followup", el, ol);
    handshake();
  endtask

  task automatic test_back_to_back();
    int el, ol;
    run_window(1'b1, 24'b011, el, ol);
    test_verdict("b2b_window", el, ol);
    start = 1'b1; res_ready = 1'b1; tick(); res_ready = 1'b0;
    vecs++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_idle_gap: got busy=%b valid=%b, want 0 0", busy, res_valid);
    end
    tick(); start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || votes !== 3'b000) begin
      errs++;
      $display("FAIL b2b_reopen: got busy=%b votes=%b, want 1 000", busy, votes);
    end
    run_window(1'b0, 24'b110 << 9, el, ol);
    test_verdict("b2b_second", el, ol);
    handshake();
  endtask

  task automatic test_idle_immunity();
    int el, ol;
    logic [2:0] last_v;
    last_v = 3'b110;
    set_btn(3'b111); start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vecs++;
      if (busy !== 1'b0 || votes !== last_v) begin
        errs++;
        $display("FAIL idle_immunity: got busy=%b votes=%b, want 0 %b", busy, votes, last_v);
      end
    end
    start = 1'b1; tick(); start = 1'b0;
    vecs++;
    if (busy !== 1'b1 || votes !== 3'b000) begin
      errs++;
      $display("FAIL idle_open: got busy=%b votes=%b, want 1 000", busy, votes);
    end
    run_window(1'b0, {8{3'b111}}, el, ol);
    test_verdict("idle_held_capture", el, ol);
    handshake();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_reset_mid();
    test_early_unanimous();
    test_timeout_majority();
    test_minority_and_empty();
    test_stall();
    test_back_to_back();
    test_idle_immunity();
    vecs++;
    if (sb.size() !== 0) begin
      errs++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/judge3_vote_panel.md
Name: judge3_vote_panel

Overview:
Front end that feeds the three-input majority judge. It opens a timed voting window on request and latches each judge's button press. When all three have voted or the window expires, it presents the majority verdict over a valid/ready handshake. It sits between the three judge button inputs and the downstream display or score logic.

Parameters:
WIN_CYCLES, 1000, length of the voting window in clock cycles (legal range >= 2).

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  opens a voting window; sampled only in IDLE.
btn_a  input  1  judge A vote, active-high, already synchronous to clk.
btn_b  input  1  judge B vote, active-high, already synchronous to clk.
btn_c  input  1  judge C vote, active-high, already synchronous to clk.
busy  output  1  high in VOTE and DONE.
votes  output  3  latched votes {a,b,c}.
res_valid  output  1  verdict available (DONE state).
res_ready  input  1  consumer accepts the verdict.
pass  output  1  majority verdict; 1 when at least two votes are latched.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, votes=3'b000, res_valid=0, pass=0, cnt=0. Reset asserted mid-window or in DONE aborts immediately, with no partial verdict.
- State IDLE: busy=0, res_valid=0.
  - start=1 at an edge: next state VOTE, votes<=0, cnt<=0.
  - Buttons are ignored in IDLE.
- State VOTE: busy=1.
  - Each edge: votes <= votes | {btn_a,btn_b,btn_c}. Votes are sticky; releasing a button does not retract a vote.
  - cnt increments by 1 per VOTE cycle. Width is clog2(WIN_CYCLES+1).
  - Exit to DONE at the edge where the updated votes equal 3'b111, or where cnt == WIN_CYCLES-1, whichever comes first. A press on that same exit cycle is counted.
  - VOTE therefore lasts at most WIN_CYCLES cycles.
  - start is ignored.
- State DONE: busy=1, res_valid=1.
  - pass = (a&b)|(a&c)|(b&c) of the latched votes. It is registered on entry to DONE and is valid on the same cycle as res_valid.
  - votes and pass stay stable while res_valid=1 and res_ready=0.
  - Buttons and start are ignored.
  - res_ready=1 at an edge: next state IDLE, res_valid<=0, busy<=0. votes and pass hold their last values until the next start.
  - If start=1 and res_ready=1 on the same cycle in DONE, only the handshake completes. start must be re-sampled in IDLE, so there is no back-to-back window without one IDLE cycle.
- res_ready has no effect outside DONE.
- Zero votes: the window expires, pass=0, votes=3'b000.

Test Plan:
All scenarios use WIN_CYCLES=8.
1. Reset mid-operation: rst_n=0 asserted between edges while in VOTE with votes=3'b101 -> outputs go to reset values immediately, without waiting for a clock edge.
2. Early unanimous: start pulse; btn_a cycle 1, btn_b cycle 2, btn_c cycle 3 -> DONE entered after the cycle-3 edge; votes=3'b111, pass=1, res_valid=1 before the window expires.
3. Timeout with majority: start; btn_b held 1 cycle at cycle 1 and released; btn_c at cycle 7 (the last window cycle) -> DONE after exactly 8 VOTE cycles; votes=3'b011, pass=1.
4. Timeout with minority and no votes: window with only btn_a pulsed -> votes=3'b100, pass=0. A second window with no presses -> votes=3'b000, pass=0.
5. Handshake stall: in DONE, hold res_ready=0 for 5 cycles while toggling all buttons and start -> res_valid, votes and pass unchanged. Then res_ready=1 -> IDLE next cycle; start in that IDLE cycle opens a new window with votes cleared.
6. Idle immunity: buttons held high in IDLE with start=0 for 10 cycles -> busy=0 and votes unchanged. Then start=1 -> VOTE with votes cleared, and held buttons are captured on the first VOTE edge.
